// File: rtl/fifo_pkg.sv
// Shared helpers for the variable-count FIFOs: count/pointer width derivation,
// saturating minimum and modulo-depth pointer addition.
package fifo_pkg;

   localparam int unsigned DEF_WORD_WIDTH         = 8;
   localparam int unsigned DEF_WORD_CNT_PER_WRITE = 4;
   localparam int unsigned DEF_WORD_CNT_PER_READ  = 4;
   localparam int unsigned DEF_WORD_FIFO_DEPTH    = 12;

   // Bits needed to hold a count in 0..n.
   function automatic int unsigned cnt_width(input int unsigned n);
      return unsigned'($clog2(n + 1));
   endfunction

   // Bits needed to hold a pointer in 0..depth-1 (at least one bit).
   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth > 1) ? unsigned'($clog2(depth)) : 1;
   endfunction

   function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
      return (a < b) ? a : b;
   endfunction

   // Single conditional subtract is enough because n never exceeds depth.
   function automatic int unsigned wrap_add(input int unsigned ptr, input int unsigned n,
                                            input int unsigned depth);
      int unsigned s;
      s = ptr + n;
      return (s >= depth) ? s - depth : s;
   endfunction

endpackage

// File: rtl/fifo_anyrw_wrapadd.sv
// Modulo-DEPTH pointer adder; works for any depth, not just powers of two.
module fifo_anyrw_wrapadd
   import fifo_pkg::*;
#(
   parameter int unsigned DEPTH     = 12,
   parameter int unsigned PTR_WIDTH = 4,
   parameter int unsigned N_WIDTH   = 3
) (
   input  logic [PTR_WIDTH-1:0] ptr,
   input  logic [N_WIDTH-1:0]   n,
   output logic [PTR_WIDTH-1:0] sum
);

   // ptr + n folded back into 0..DEPTH-1
   assign sum = PTR_WIDTH'(wrap_add(32'(ptr), 32'(n), DEPTH));

endmodule

// File: rtl/fifo_anyrw.sv
// Multi-word FIFO with variable-count push and pop per cycle. Transfers are
// clamped to available space/data from the registered level only, so a pop
// never frees space for a same-cycle push and a push is never readable in
// the cycle it is written. Head words are presented fall-through on data_o.
module fifo_anyrw
   import fifo_pkg::*;
#(
   parameter int unsigned WORD_WIDTH         = DEF_WORD_WIDTH,
   parameter int unsigned WORD_CNT_PER_WRITE = DEF_WORD_CNT_PER_WRITE,
   parameter int unsigned WORD_CNT_PER_READ  = DEF_WORD_CNT_PER_READ,
   parameter int unsigned WORD_FIFO_DEPTH    = DEF_WORD_FIFO_DEPTH,
   parameter int unsigned ALMOST_FULL_LVL    = WORD_FIFO_DEPTH - WORD_CNT_PER_WRITE,
   parameter int unsigned ALMOST_EMPTY_LVL   = WORD_CNT_PER_READ,
   localparam int unsigned WRITE_WIDTH       = cnt_width(WORD_CNT_PER_WRITE),
   localparam int unsigned READ_WIDTH        = cnt_width(WORD_CNT_PER_READ),
   localparam int unsigned LEVEL_WIDTH       = cnt_width(WORD_FIFO_DEPTH)
) (
   input  logic                                            clk_i,
   input  logic                                            rst_i,
   input  logic                                            flush_i,
   input  logic [WRITE_WIDTH-1:0]                          write_i,
   input  logic [WORD_CNT_PER_WRITE-1:0][WORD_WIDTH-1:0]   data_i,
   output logic [WRITE_WIDTH-1:0]                          wr_space_o,
   output logic [WRITE_WIDTH-1:0]                          wr_accepted_o,
   input  logic [READ_WIDTH-1:0]                           read_i,
   output logic [WORD_CNT_PER_READ-1:0][WORD_WIDTH-1:0]    data_o,
   output logic [READ_WIDTH-1:0]                           rd_avail_o,
   output logic [READ_WIDTH-1:0]                           rd_granted_o,
   output logic [LEVEL_WIDTH-1:0]                          level_o,
   output logic                                            almost_full_o,
   output logic                                            almost_empty_o
);

   localparam int unsigned PTR_WIDTH = ptr_width(WORD_FIFO_DEPTH);

   logic [WORD_WIDTH-1:0]         mem [WORD_FIFO_DEPTH];
   logic [LEVEL_WIDTH-1:0]        level;
   logic [LEVEL_WIDTH-1:0]        free;
   logic [PTR_WIDTH-1:0]          wr_ptr;
   logic [PTR_WIDTH-1:0]          rd_ptr;
   logic [PTR_WIDTH-1:0]          wr_ptr_nxt;
   logic [PTR_WIDTH-1:0]          rd_ptr_nxt;
   logic [PTR_WIDTH-1:0]          wr_addr [WORD_CNT_PER_WRITE];
   logic [PTR_WIDTH-1:0]          rd_addr [WORD_CNT_PER_READ];
   logic [WORD_CNT_PER_WRITE-1:0] lane_we;
   logic                          clear;

   // Reset behaves exactly like a flush, including zeroing this cycle's counts.
   assign clear = rst_i | flush_i;
   assign free  = LEVEL_WIDTH'(WORD_FIFO_DEPTH) - level;

   assign wr_space_o    = WRITE_WIDTH'(min_u(32'(free), WORD_CNT_PER_WRITE));
   assign rd_avail_o    = READ_WIDTH'(min_u(32'(level), WORD_CNT_PER_READ));
   assign wr_accepted_o = clear ? '0 :
      WRITE_WIDTH'(min_u(min_u(32'(write_i), WORD_CNT_PER_WRITE), 32'(free)));
   assign rd_granted_o  = clear ? '0 :
      READ_WIDTH'(min_u(min_u(32'(read_i), WORD_CNT_PER_READ), 32'(level)));

   assign level_o        = level;
   assign almost_full_o  = 32'(level) >= ALMOST_FULL_LVL;
   assign almost_empty_o = 32'(level) <= ALMOST_EMPTY_LVL;

   // Per write lane: target address and enable from the accepted count.
   for (genvar i = 0; i < WORD_CNT_PER_WRITE; i++) begin : g_wr_lane
      fifo_anyrw_wrapadd #(
         .DEPTH     (WORD_FIFO_DEPTH),
         .PTR_WIDTH (PTR_WIDTH),
         .N_WIDTH   (PTR_WIDTH)
      ) u_wr_addr (
         .ptr (wr_ptr),
         .n   (PTR_WIDTH'(i)),
         .sum (wr_addr[i])
      );
      assign lane_we[i] = 32'(wr_accepted_o) > 32'(i);
   end

   // Per read lane: fall-through view of the head words.
   for (genvar i = 0; i < WORD_CNT_PER_READ; i++) begin : g_rd_lane
      fifo_anyrw_wrapadd #(
         .DEPTH     (WORD_FIFO_DEPTH),
         .PTR_WIDTH (PTR_WIDTH),
         .N_WIDTH   (PTR_WIDTH)
      ) u_rd_addr (
         .ptr (rd_ptr),
         .n   (PTR_WIDTH'(i)),
         .sum (rd_addr[i])
      );
      assign data_o[i] = mem[rd_addr[i]];
   end

   fifo_anyrw_wrapadd #(
      .DEPTH     (WORD_FIFO_DEPTH),
      .PTR_WIDTH (PTR_WIDTH),
      .N_WIDTH   (WRITE_WIDTH)
   ) u_wr_ptr_nxt (
      .ptr (wr_ptr),
      .n   (wr_accepted_o),
      .sum (wr_ptr_nxt)
   );

   fifo_anyrw_wrapadd #(
      .DEPTH     (WORD_FIFO_DEPTH),
      .PTR_WIDTH (PTR_WIDTH),
      .N_WIDTH   (READ_WIDTH)
   ) u_rd_ptr_nxt (
      .ptr (rd_ptr),
      .n   (rd_granted_o),
      .sum (rd_ptr_nxt)
   );

   // Level and pointers; push and pop apply together, clear wins over both.
   always_ff @(posedge clk_i) begin
      if (clear) begin
         level  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         level  <= level + LEVEL_WIDTH'(wr_accepted_o) - LEVEL_WIDTH'(rd_granted_o);
         wr_ptr <= wr_ptr_nxt;
         rd_ptr <= rd_ptr_nxt;
      end
   end

   // Word storage, no reset; enables are already zero while clearing.
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < int'(WORD_CNT_PER_WRITE); i++) begin
         if (lane_we[i]) mem[wr_addr[i]] <= data_i[i];
      end
   end

endmodule

// File: tb/tb_fifo_anyrw.sv
// Directed and randomized checks of fifo_anyrw at DEPTH=12, W=R=4.
module tb_fifo_anyrw;

   logic            clk_i = 1'b0;
   logic            rst_i;
   logic            flush_i;
   logic [2:0]      write_i;
   logic [3:0][7:0] data_i;
   logic [2:0]      wr_space_o;
   logic [2:0]      wr_accepted_o;
   logic [2:0]      read_i;
   logic [3:0][7:0] data_o;
   logic [2:0]      rd_avail_o;
   logic [2:0]      rd_granted_o;
   logic [3:0]      level_o;
   logic            almost_full_o;
   logic            almost_empty_o;

   int passed = 0;
   int total  = 0;

   fifo_anyrw dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .flush_i        (flush_i),
      .write_i        (write_i),
      .data_i         (data_i),
      .wr_space_o     (wr_space_o),
      .wr_accepted_o  (wr_accepted_o),
      .read_i         (read_i),
      .data_o         (data_o),
      .rd_avail_o     (rd_avail_o),
      .rd_granted_o   (rd_granted_o),
      .level_o        (level_o),
      .almost_full_o  (almost_full_o),
      .almost_empty_o (almost_empty_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic drive(input int w, input int r, input bit f, input logic [7:0] base);
      write_i = 3'(w);
      read_i  = 3'(r);
      flush_i = f;
      for (int i = 0; i < 4; i++) data_i[i] = (i < w) ? base + 8'(i) : 8'hEE;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      drive(4, 4, 0, 8'h01);
      #4;
      total++;
      if (wr_accepted_o !== 3'd0) $display("FAIL rst_acc got %0d want 0", wr_accepted_o);
      else passed++;
      total++;
      if (rd_granted_o !== 3'd0) $display("FAIL rst_gnt got %0d want 0", rd_granted_o);
      else passed++;
      tick();
      tick();
      rst_i = 1'b0;
      drive(0, 0, 0, 8'h00);
      #4;
      total++;
      if (level_o !== 4'd0) $display("FAIL rst_level got %0d want 0", level_o);
      else passed++;
      total++;
      if (wr_space_o !== 3'd4) $display("FAIL rst_space got %0d want 4", wr_space_o);
      else passed++;
      total++;
      if (rd_avail_o !== 3'd0) $display("FAIL rst_avail got %0d want 0", rd_avail_o);
      else passed++;
      total++;
      if ({almost_full_o, almost_empty_o} !== 2'b01)
         $display("FAIL rst_flags got af=%b ae=%b want af=0 ae=1", almost_full_o, almost_empty_o);
      else passed++;
      tick();
   endtask

   task automatic test_fill();
      int  exp_acc [4] = '{4, 4, 4, 0};
      int  exp_sp  [4] = '{4, 4, 4, 0};
      int  exp_lvl [4] = '{4, 8, 12, 12};
      bit  exp_af  [4] = '{0, 1, 1, 1};
      bit  exp_ae  [4] = '{1, 0, 0, 0};
      for (int k = 0; k < 4; k++) begin
         drive(4, 0, 0, 8'(1 + 4 * k));
         #4;
         total++;
         if (wr_space_o !== 3'(exp_sp[k]))
            $display("FAIL fill_space[%0d] got %0d want %0d", k, wr_space_o, exp_sp[k]);
         else passed++;
         total++;
         if (wr_accepted_o !== 3'(exp_acc[k]))
            $display("FAIL fill_acc[%0d] got %0d want %0d", k, wr_accepted_o, exp_acc[k]);
         else passed++;
         tick();
         total++;
         if (level_o !== 4'(exp_lvl[k]))
            $display("FAIL fill_level[%0d] got %0d want %0d", k, level_o, exp_lvl[k]);
         else passed++;
         total++;
         if (almost_full_o !== exp_af[k] || almost_empty_o !== exp_ae[k])
            $display("FAIL fill_flags[%0d] got af=%b ae=%b want af=%b ae=%b", k,
                     almost_full_o, almost_empty_o, exp_af[k], exp_ae[k]);
         else passed++;
      end
      for (int k = 0; k < 3; k++) begin
         drive(0, 4, 0, 8'h00);
         #4;
         total++;
         if (rd_granted_o !== 3'd4) $display("FAIL drain_gnt[%0d] got %0d want 4", k, rd_granted_o);
         else passed++;
         for (int i = 0; i < 4; i++) begin
            total++;
            if (data_o[i] !== 8'(1 + 4 * k + i))
               $display("FAIL drain_data[%0d][%0d] got %h want %h", k, i, data_o[i], 8'(1 + 4 * k + i));
            else passed++;
         end
         tick();
      end
      total++;
      if (level_o !== 4'd0 || almost_empty_o !== 1'b1)
         $display("FAIL drain_level got %0d ae=%b want 0 ae=1", level_o, almost_empty_o);
      else passed++;
   endtask

   // Moves pointers to 3 so both the pushes and the pops straddle the wrap.
   task automatic test_wrap_partial();
      logic [7:0] exp_d;
      drive(3, 0, 0, 8'h20);
      tick();
      drive(0, 3, 0, 8'h00);
      #4;
      total++;
      if (rd_granted_o !== 3'd3 || data_o[2] !== 8'h22)
         $display("FAIL wrap_pre got gnt=%0d d2=%h want gnt=3 d2=22", rd_granted_o, data_o[2]);
      else passed++;
      tick();
      drive(4, 0, 0, 8'h30);
      tick();
      drive(4, 0, 0, 8'h34);
      tick();
      drive(2, 0, 0, 8'h38);
      tick();
      drive(4, 0, 0, 8'h3A);
      #4;
      total++;
      if (wr_space_o !== 3'd2) $display("FAIL wrap_space got %0d want 2", wr_space_o);
      else passed++;
      total++;
      if (wr_accepted_o !== 3'd2) $display("FAIL wrap_acc got %0d want 2", wr_accepted_o);
      else passed++;
      tick();
      total++;
      if (level_o !== 4'd12 || almost_full_o !== 1'b1)
         $display("FAIL wrap_level got %0d af=%b want 12 af=1", level_o, almost_full_o);
      else passed++;
      for (int k = 0; k < 3; k++) begin
         drive(0, 4, 0, 8'h00);
         #4;
         for (int i = 0; i < 4; i++) begin
            exp_d = 8'h30 + 8'(4 * k + i);
            total++;
            if (data_o[i] !== exp_d)
               $display("FAIL wrap_data[%0d][%0d] got %h want %h", k, i, data_o[i], exp_d);
            else passed++;
         end
         tick();
      end
      total++;
      if (level_o !== 4'd0) $display("FAIL wrap_end_level got %0d want 0", level_o);
      else passed++;
   endtask

   task automatic test_simultaneous();
      logic [7:0] exp_d [4] = '{8'h44, 8'h50, 8'h51, 8'h52};
      drive(4, 0, 0, 8'h40);
      tick();
      drive(1, 0, 0, 8'h44);
      tick();
      total++;
      if (level_o !== 4'd5) $display("FAIL sim_pre_level got %0d want 5", level_o);
      else passed++;
      drive(3, 4, 0, 8'h50);
      #4;
      total++;
      if (rd_granted_o !== 3'd4 || wr_accepted_o !== 3'd3)
         $display("FAIL sim_counts got gnt=%0d acc=%0d want gnt=4 acc=3", rd_granted_o, wr_accepted_o);
      else passed++;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (data_o[i] !== 8'h40 + 8'(i))
            $display("FAIL sim_data[%0d] got %h want %h", i, data_o[i], 8'h40 + 8'(i));
         else passed++;
      end
      tick();
      total++;
      if (level_o !== 4'd4) $display("FAIL sim_level got %0d want 4", level_o);
      else passed++;
      drive(0, 7, 0, 8'h00);
      #4;
      total++;
      if (rd_granted_o !== 3'd4) $display("FAIL sim_clamp_gnt got %0d want 4", rd_granted_o);
      else passed++;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (data_o[i] !== exp_d[i])
            $display("FAIL sim_tail[%0d] got %h want %h", i, data_o[i], exp_d[i]);
         else passed++;
      end
      tick();
      total++;
      if (level_o !== 4'd0) $display("FAIL sim_end_level got %0d want 0", level_o);
      else passed++;
   endtask

   task automatic test_underflow();
      drive(2, 0, 0, 8'h60);
      tick();
      drive(7, 4, 0, 8'h70);
      #4;
      total++;
      if (rd_granted_o !== 3'd2 || rd_avail_o !== 3'd2)
         $display("FAIL uf_gnt got gnt=%0d avail=%0d want 2/2", rd_granted_o, rd_avail_o);
      else passed++;
      total++;
      if (wr_accepted_o !== 3'd4) $display("FAIL uf_acc_clamp got %0d want 4", wr_accepted_o);
      else passed++;
      total++;
      if (data_o[0] !== 8'h60 || data_o[1] !== 8'h61)
         $display("FAIL uf_data got %h %h want 60 61", data_o[0], data_o[1]);
      else passed++;
      tick();
      total++;
      if (level_o !== 4'd4) $display("FAIL uf_level got %0d want 4", level_o);
      else passed++;
      drive(0, 4, 0, 8'h00);
      #4;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (data_o[i] !== 8'h70 + 8'(i))
            $display("FAIL uf_after[%0d] got %h want %h", i, data_o[i], 8'h70 + 8'(i));
         else passed++;
      end
      tick();
   endtask

   task automatic test_flush();
      drive(4, 0, 0, 8'h80);
      tick();
      drive(3, 0, 0, 8'h84);
      tick();
      drive(4, 4, 1, 8'h90);
      #4;
      total++;
      if (wr_accepted_o !== 3'd0 || rd_granted_o !== 3'd0)
         $display("FAIL fl_counts got acc=%0d gnt=%0d want 0/0", wr_accepted_o, rd_granted_o);
      else passed++;
      tick();
      drive(1, 0, 0, 8'hA0);
      #4;
      total++;
      if (level_o !== 4'd0 || almost_empty_o !== 1'b1 || rd_avail_o !== 3'd0)
         $display("FAIL fl_state got lvl=%0d ae=%b avail=%0d want 0 1 0",
                  level_o, almost_empty_o, rd_avail_o);
      else passed++;
      tick();
      drive(0, 4, 0, 8'h00);
      #4;
      total++;
      if (rd_granted_o !== 3'd1 || data_o[0] !== 8'hA0)
         $display("FAIL fl_after got gnt=%0d d0=%h want 1 a0", rd_granted_o, data_o[0]);
      else passed++;
      tick();
   endtask

   task automatic test_reset_mid();
      drive(4, 0, 0, 8'hB0);
      tick();
      rst_i = 1'b1;
      drive(4, 4, 0, 8'hC0);
      #4;
      total++;
      if (wr_accepted_o !== 3'd0 || rd_granted_o !== 3'd0)
         $display("FAIL rm_counts got acc=%0d gnt=%0d want 0/0", wr_accepted_o, rd_granted_o);
      else passed++;
      tick();
      rst_i = 1'b0;
      drive(0, 0, 0, 8'h00);
      #4;
      total++;
      if (level_o !== 4'd0 || rd_avail_o !== 3'd0)
         $display("FAIL rm_level got lvl=%0d avail=%0d want 0 0", level_o, rd_avail_o);
      else passed++;
      tick();
   endtask

   task automatic test_stress();
      logic [7:0] model [$];
      int w, r, acc, gnt, avail;
      bit f;
      model.delete();
      for (int c = 0; c < 3000; c++) begin
         w = int'($urandom_range(0, 7));
         r = int'($urandom_range(0, 7));
         f = ($urandom_range(0, 31) == 0);
         drive(w, r, f, 8'($urandom));
         #4;
         acc   = f ? 0 : ((w > 4 ? 4 : w) < 12 - model.size() ? (w > 4 ? 4 : w) : 12 - model.size());
         gnt   = f ? 0 : ((r > 4 ? 4 : r) < model.size() ? (r > 4 ? 4 : r) : model.size());
         avail = model.size() < 4 ? model.size() : 4;
         total++;
         if (level_o !== 4'(model.size()))
            $display("FAIL st_level[%0d] got %0d want %0d", c, level_o, model.size());
         else passed++;
         total++;
         if (wr_accepted_o !== 3'(acc) || rd_granted_o !== 3'(gnt))
            $display("FAIL st_counts[%0d] got acc=%0d gnt=%0d want %0d %0d",
                     c, wr_accepted_o, rd_granted_o, acc, gnt);
         else passed++;
         total++;
         if (rd_avail_o !== 3'(avail))
            $display("FAIL st_avail[%0d] got %0d want %0d", c, rd_avail_o, avail);
         else passed++;
         for (int i = 0; i < avail; i++) begin
            total++;
            if (data_o[i] !== model[i])
               $display("FAIL st_data[%0d][%0d] got %h want %h", c, i, data_o[i], model[i]);
            else passed++;
         end
         if (f) model.delete();
         else begin
            for (int i = 0; i < gnt; i++) void'(model.pop_front());
            for (int i = 0; i < acc; i++) model.push_back(data_i[i]);
         end
         tick();
      end
   endtask

   initial begin
      rst_i = 1'b1;
      drive(0, 0, 0, 8'h00);
      test_reset();
      test_fill();
      test_wrap_partial();
      test_simultaneous();
      test_underflow();
      test_flush();
      test_reset_mid();
      test_stress();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
